// File: rtl/orcs_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : orcs_ctrl_pkg
// Brief    : Opcodes, writeback/ALU codes and state encoding for the ORCS
//            sequencer, plus the two-word instruction classifier.
// Revision : 1.0
// ============================================================================
package orcs_ctrl_pkg;

  localparam logic [3:0] c_op_move   = 4'h0;
  localparam logic [3:0] c_op_movei  = 4'h1;
  localparam logic [3:0] c_op_load   = 4'h4;
  localparam logic [3:0] c_op_store  = 4'h5;
  localparam logic [3:0] c_op_loadr  = 4'h6;
  localparam logic [3:0] c_op_storer = 4'h7;
  localparam logic [3:0] c_op_add    = 4'h8;
  localparam logic [3:0] c_op_sub    = 4'h9;
  localparam logic [3:0] c_op_jmpneg = 4'hC;
  localparam logic [3:0] c_op_jmpz   = 4'hD;
  localparam logic [3:0] c_op_jmp    = 4'hE;
  localparam logic [3:0] c_op_end    = 4'hF;

  localparam logic [1:0] c_wb_mem = 2'b00;
  localparam logic [1:0] c_wb_alu = 2'b01;
  localparam logic [1:0] c_wb_imm = 2'b10;

  localparam logic [2:0] c_alu_none = 3'b000;
  localparam logic [2:0] c_alu_pass = 3'b011;
  localparam logic [2:0] c_alu_add  = 3'b101;
  localparam logic [2:0] c_alu_sub  = 3'b110;

  localparam int unsigned c_state_w = 4;
  localparam logic [c_state_w-1:0] c_st_ld_pc  = 4'd0;
  localparam logic [c_state_w-1:0] c_st_f_req  = 4'd1;
  localparam logic [c_state_w-1:0] c_st_decode = 4'd2;
  localparam logic [c_state_w-1:0] c_st_exec   = 4'd3;
  localparam logic [c_state_w-1:0] c_st_m_req  = 4'd4;
  localparam logic [c_state_w-1:0] c_st_wb     = 4'd5;
  localparam logic [c_state_w-1:0] c_st_inc    = 4'd6;
  localparam logic [c_state_w-1:0] c_st_halt   = 4'd7;

  function automatic logic is_two_word(input logic [3:0] op);
    return (op == c_op_movei)  || (op == c_op_load) || (op == c_op_store) ||
           (op == c_op_jmpneg) || (op == c_op_jmpz) || (op == c_op_jmp);
  endfunction

endpackage
`default_nettype wire

// File: rtl/orcs_mem_wait.sv
`default_nettype none
// ============================================================================
// Module   : orcs_mem_wait
// Brief    : Memory req/ack completion detect with optional wait timeout
//            (enabled by ORCS_CTRL_MEM_TIMEOUT_EN).
// Revision : 1.0
// ============================================================================
module orcs_mem_wait #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic waiting,
  input  logic mem_ack,
  output logic done,
  output logic timeout
);

  assign done = waiting & mem_ack;

`ifdef ORCS_CTRL_MEM_TIMEOUT_EN
  localparam int unsigned c_raw_w = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned c_cnt_w = (c_raw_w < 8) ? 8 : ((c_raw_w > 16) ? 16 : c_raw_w);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(MEM_TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Cleared whenever idle, so every wait phase starts counting from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_cnt <= '0;
    else if (!waiting) r_cnt <= '0;
    else               r_cnt <= r_cnt + 1'b1;
  end

  assign timeout = waiting & ~mem_ack & (r_cnt == c_limit);
`else
  logic w_unused;
  assign w_unused = clk ^ reset_n;
  assign timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/orcs_seq_control.sv
`default_nettype none
// ============================================================================
// Module   : orcs_seq_control
// Brief    : Multi-cycle ORCS fetch/decode/execute sequencer with req/ack
//            memory handshake; ORCS_CTRL_MEM_TIMEOUT_EN adds a wait timeout.
// Revision : 1.0
// ============================================================================
module orcs_seq_control #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned ADDR_REG    = 15,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  input  logic [1:0]            status_register,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [REG_ADDR_W-1:0] rf_src1,
  output logic [REG_ADDR_W-1:0] rf_src2,
  output logic [REG_ADDR_W-1:0] rf_dst,
  output logic                  rf_we,
  output logic [1:0]            wb_sel,
  output logic [2:0]            alu_op,
  output logic [DATA_W-1:0]     immediate_line,
  output logic [DATA_W-1:0]     pc,
  output logic                  halted,
  output logic                  error
);
  import orcs_ctrl_pkg::*;

  localparam logic [REG_ADDR_W-1:0] c_addr_reg = REG_ADDR_W'(ADDR_REG);
  localparam logic [DATA_W-1:0]     c_reset_pc = DATA_W'(RESET_PC);

  logic [c_state_w-1:0]  r_state, w_state_next;
  logic [DATA_W-1:0]     w_pc_next, r_ir1, r_ir2, w_ir1_next, w_ir2_next;
  logic                  r_second, w_second_next, w_error_next;
  logic                  w_waiting, w_done, w_timeout, w_is_load, w_is_store;
  logic [3:0]            w_op;
  logic [REG_ADDR_W-1:0] w_dst, w_src;

  logic                  w_mem_req, w_mem_we, w_rf_we, w_halted;
  logic [REG_ADDR_W-1:0] w_rf_src1, w_rf_src2, w_rf_dst;
  logic [1:0]            w_wb_sel;
  logic [2:0]            w_alu_op;
  logic [DATA_W-1:0]     w_imm;

  assign w_op       = r_ir1[3:0];
  assign w_dst      = REG_ADDR_W'(r_ir1[7:4]);
  assign w_src      = REG_ADDR_W'(r_ir1[11:8]);
  assign w_is_load  = (w_op == c_op_load)  || (w_op == c_op_loadr);
  assign w_is_store = (w_op == c_op_store) || (w_op == c_op_storer);
  assign w_waiting  = (r_state == c_st_f_req) || (r_state == c_st_m_req);

  if (DATA_W > 12) begin : g_ir_hi_unused
    logic w_unused_hi;
    assign w_unused_hi = ^r_ir1[DATA_W-1:12];
  end

  orcs_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .waiting (w_waiting),
    .mem_ack (mem_ack),
    .done    (w_done),
    .timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= c_st_ld_pc;
      pc       <= c_reset_pc;
      r_ir1    <= '0;
      r_ir2    <= '0;
      r_second <= 1'b0;
      error    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      pc       <= w_pc_next;
      r_ir1    <= w_ir1_next;
      r_ir2    <= w_ir2_next;
      r_second <= w_second_next;
      error    <= w_error_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = pc;
    w_ir1_next    = r_ir1;
    w_ir2_next    = r_ir2;
    w_second_next = r_second;
    w_error_next  = error;
    case (r_state)
      // Right after reset the outputs are still cleared, so LD_PC lingers
      // one cycle to actually present the pc load before fetching.
      c_st_ld_pc: if (rf_we) w_state_next = c_st_f_req;
      c_st_f_req: begin
        if (w_done) begin
          if (r_second) w_ir2_next = mem_rdata;
          else          w_ir1_next = mem_rdata;
          w_state_next = c_st_decode;
        end else if (w_timeout) begin
          w_error_next = 1'b1;
          w_state_next = c_st_halt;
        end
      end
      c_st_decode: begin
        if (is_two_word(w_op) && !r_second) begin
          w_pc_next     = pc + 1'b1;
          w_second_next = 1'b1;
          w_state_next  = c_st_ld_pc;
        end else begin
          w_second_next = 1'b0;
          w_state_next  = c_st_exec;
        end
      end
      c_st_exec: begin
        case (w_op)
          c_op_move, c_op_movei, c_op_add, c_op_sub: w_state_next = c_st_inc;
          c_op_load, c_op_store, c_op_loadr, c_op_storer: w_state_next = c_st_m_req;
          c_op_jmp, c_op_jmpneg, c_op_jmpz: begin
            if ((w_op == c_op_jmp) ||
                ((w_op == c_op_jmpneg) && status_register[0]) ||
                ((w_op == c_op_jmpz) && status_register[1])) begin
              w_pc_next    = r_ir2;
              w_state_next = c_st_ld_pc;
            end else begin
              w_state_next = c_st_inc;
            end
          end
          default: w_state_next = c_st_halt;
        endcase
      end
      c_st_m_req: begin
        if (w_done) begin
          w_state_next = w_is_load ? c_st_wb : c_st_inc;
        end else if (w_timeout) begin
          w_error_next = 1'b1;
          w_state_next = c_st_halt;
        end
      end
      c_st_wb: w_state_next = c_st_inc;
      c_st_inc: begin
        w_pc_next    = pc + 1'b1;
        w_state_next = c_st_ld_pc;
      end
      c_st_halt: w_state_next = c_st_halt;
      default:   w_state_next = c_st_halt;
    endcase
  end

  // Outputs are decoded from the state being entered and then registered,
  // so each state's controls appear exactly while that state is current.
  always_comb begin
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_rf_src1 = '0;
    w_rf_src2 = '0;
    w_rf_dst  = '0;
    w_rf_we   = 1'b0;
    w_wb_sel  = c_wb_mem;
    w_alu_op  = c_alu_none;
    w_imm     = '0;
    w_halted  = 1'b0;
    case (w_state_next)
      c_st_ld_pc: begin
        w_imm    = w_pc_next;
        w_wb_sel = c_wb_imm;
        w_rf_dst = c_addr_reg;
        w_rf_we  = 1'b1;
      end
      c_st_f_req: begin
        w_rf_src1 = c_addr_reg;
        w_mem_req = 1'b1;
      end
      c_st_exec: begin
        case (w_op)
          c_op_move: begin
            w_rf_src1 = w_src; w_alu_op = c_alu_pass; w_wb_sel = c_wb_alu;
            w_rf_dst  = w_dst; w_rf_we  = 1'b1;
          end
          c_op_movei: begin
            w_imm    = r_ir2; w_wb_sel = c_wb_imm;
            w_rf_dst = w_dst; w_rf_we  = 1'b1;
          end
          c_op_add: begin
            w_rf_src1 = w_dst; w_rf_src2 = w_src; w_alu_op = c_alu_add;
            w_wb_sel  = c_wb_alu; w_rf_dst = w_dst; w_rf_we = 1'b1;
          end
          c_op_sub: begin
            w_rf_src1 = w_src; w_rf_src2 = w_dst; w_alu_op = c_alu_sub;
            w_wb_sel  = c_wb_alu; w_rf_dst = w_dst; w_rf_we = 1'b1;
          end
          c_op_load, c_op_store: begin
            w_imm    = r_ir2; w_wb_sel = c_wb_imm;
            w_rf_dst = c_addr_reg; w_rf_we = 1'b1;
          end
          c_op_loadr, c_op_storer: begin
            w_rf_src1 = w_src; w_alu_op = c_alu_pass; w_wb_sel = c_wb_alu;
            w_rf_dst  = c_addr_reg; w_rf_we = 1'b1;
          end
          default: ;
        endcase
      end
      c_st_m_req: begin
        w_rf_src1 = c_addr_reg;
        w_mem_req = 1'b1;
        if (w_is_store) begin
          w_mem_we  = 1'b1;
          w_rf_src2 = w_dst;
        end
      end
      c_st_wb: begin
        // Load data is captured here; it stays on immediate_line during WB.
        w_imm    = mem_rdata;
        w_wb_sel = c_wb_mem;
        w_rf_dst = w_dst;
        w_rf_we  = 1'b1;
      end
      c_st_halt: w_halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      rf_src1        <= '0;
      rf_src2        <= '0;
      rf_dst         <= '0;
      rf_we          <= 1'b0;
      wb_sel         <= c_wb_mem;
      alu_op         <= c_alu_none;
      immediate_line <= '0;
      halted         <= 1'b0;
    end else begin
      mem_req        <= w_mem_req;
      mem_we         <= w_mem_we;
      rf_src1        <= w_rf_src1;
      rf_src2        <= w_rf_src2;
      rf_dst         <= w_rf_dst;
      rf_we          <= w_rf_we;
      wb_sel         <= w_wb_sel;
      alu_op         <= w_alu_op;
      immediate_line <= w_imm;
      halted         <= w_halted;
    end
  end

endmodule
`default_nettype wire
